hdlc_rx_protocol_monitor: RTL and testbench

//  Synthesizable, multi-channel HDLC Rx protocol checker; runs in sim and on FPGA alongside N Rx channels.
//  Per channel: detects flag (0111_1110) and abort (0 then 7x1) patterns on the serial Rx line.

---
 rtl/hdlc_rx_protocol_monitor.sv | 152 +++++++++++++++
 tb/tb_hdlc_rx_protocol_monitor.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_rx_protocol_monitor.sv
// Purpose : HDLC Rx protocol checker; per channel it finds flag/abort patterns on Rx and checks the receiver's strobes.
// Latency : flag/abort strobes are checked FLAG_LATENCY/ABORT_LATENCY edges after the pattern, AbortSignal one edge after AbortDetect&&ValidFrame; status outputs are registered.
// Backpres: none; a passive observer that accepts every cycle, and the monitored receiver is never stalled.
//
// Ports:
//   Clk, Rst (sync, active-high), En (launch new checks), Clr (clear count and sticky status)
//   Rx, Rx_FlagDetect, Rx_AbortDetect, Rx_ValidFrame, Rx_AbortSignal : one bit per channel
//   ErrCnt  : saturating total violation count
//   ErrChan : sticky per-channel violation flags
//   ErrType : sticky {abort-signal, abort-detect, flag}
//   ErrNow  : at least one violation was seen at the previous edge
// Optional build macro HDLC_MON_FIRST_ERR_CAPTURE_EN adds FirstErrValid/Time/Chan/Type,
// which record the first violation since Rst or Clr against a free-running cycle counter.
module hdlc_rx_protocol_monitor #(
    parameter int CHANNELS      = 1,
    parameter int FLAG_LATENCY  = 2,
    parameter int ABORT_LATENCY = 1,
    parameter int CNT_W         = 16,
    localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                En,
    input  logic                Clr,
    input  logic [CHANNELS-1:0] Rx,
    input  logic [CHANNELS-1:0] Rx_FlagDetect,
    input  logic [CHANNELS-1:0] Rx_AbortDetect,
    input  logic [CHANNELS-1:0] Rx_ValidFrame,
    input  logic [CHANNELS-1:0] Rx_AbortSignal,
    output logic [CNT_W-1:0]    ErrCnt,
    output logic [CHANNELS-1:0] ErrChan,
    output logic [2:0]          ErrType,
    output logic                ErrNow
`ifdef HDLC_MON_FIRST_ERR_CAPTURE_EN
    ,
    output logic                FirstErrValid,
    output logic [31:0]         FirstErrTime,
    output logic [CH_W-1:0]     FirstErrChan,
    output logic [2:0]          FirstErrType
`endif
);

    localparam int V_W   = $clog2(3 * CHANNELS + 1);
    localparam int SUM_W = CNT_W + V_W + 1;

    // Only the 7 most recent bits need storing; the 8th window bit is the live Rx.
    logic [6:0]          hist [CHANNELS];
    logic [CHANNELS-1:0] flagPipe  [FLAG_LATENCY];
    logic [CHANNELS-1:0] abortPipe [ABORT_LATENCY];
    logic [CHANNELS-1:0] sigPend;

    logic [CHANNELS-1:0] flagMatch, abortMatch, sigLaunch;
    logic [CHANNELS-1:0] flagViol, abortViol, sigViol, chanViol;
    logic [2:0]          typeViol;
    logic [V_W-1:0]      vCnt;
    logic [SUM_W-1:0]    sum;
    logic [CNT_W-1:0]    cntNext;

    always_comb begin
        logic [7:0] win;
        win        = '0;
        flagMatch  = '0;
        abortMatch = '0;
        vCnt       = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            win           = {hist[c], Rx[c]};
            flagMatch[c]  = En && (win == 8'b0111_1110);
            abortMatch[c] = En && (win == 8'b0111_1111);
        end
        sigLaunch = {CHANNELS{En}} & Rx_AbortDetect & Rx_ValidFrame;

        flagViol  = flagPipe[FLAG_LATENCY-1]   & ~Rx_FlagDetect;
        abortViol = abortPipe[ABORT_LATENCY-1] & ~Rx_AbortDetect;
        sigViol   = sigPend & ~Rx_AbortSignal;
        chanViol  = flagViol | abortViol | sigViol;
        typeViol  = {|sigViol, |abortViol, |flagViol};

        for (int c = 0; c < CHANNELS; c++) begin
            vCnt = vCnt + V_W'(flagViol[c]) + V_W'(abortViol[c]) + V_W'(sigViol[c]);
        end

        // Clr restarts the count from this edge's violations rather than from zero.
        sum     = (Clr ? '0 : SUM_W'(ErrCnt)) + SUM_W'(vCnt);
        cntNext = (|sum[SUM_W-1:CNT_W]) ? '1 : sum[CNT_W-1:0];
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            for (int c = 0; c < CHANNELS; c++) hist[c] <= '1;
            for (int i = 0; i < FLAG_LATENCY; i++)  flagPipe[i]  <= '0;
            for (int i = 0; i < ABORT_LATENCY; i++) abortPipe[i] <= '0;
            sigPend <= '0;
            ErrCnt  <= '0;
            ErrChan <= '0;
            ErrType <= '0;
            ErrNow  <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) hist[c] <= {hist[c][5:0], Rx[c]};
            flagPipe[0] <= flagMatch;
            for (int i = 1; i < FLAG_LATENCY; i++)  flagPipe[i]  <= flagPipe[i-1];
            abortPipe[0] <= abortMatch;
            for (int i = 1; i < ABORT_LATENCY; i++) abortPipe[i] <= abortPipe[i-1];
            sigPend <= sigLaunch;
            ErrCnt  <= cntNext;
            ErrChan <= Clr ? chanViol : (ErrChan | chanViol);
            ErrType <= Clr ? typeViol : (ErrType | typeViol);
            ErrNow  <= |chanViol;
        end
    end

`ifdef HDLC_MON_FIRST_ERR_CAPTURE_EN
    logic [31:0]     cycleCnt;
    logic [CH_W-1:0] firstChan;
    logic [2:0]      firstType;

    // Walk from the top down so the lowest violating channel wins.
    always_comb begin
        firstChan = '0;
        firstType = '0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (chanViol[c]) begin
                firstChan = CH_W'(c);
                firstType = {sigViol[c], abortViol[c], flagViol[c]};
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cycleCnt      <= '0;
            FirstErrValid <= 1'b0;
            FirstErrTime  <= '0;
            FirstErrChan  <= '0;
            FirstErrType  <= '0;
        end else begin
            cycleCnt <= cycleCnt + 32'd1;
            if ((|chanViol) && (Clr || !FirstErrValid)) begin
                FirstErrValid <= 1'b1;
                FirstErrTime  <= cycleCnt;
                FirstErrChan  <= firstChan;
                FirstErrType  <= firstType;
            end else if (Clr) begin
                FirstErrValid <= 1'b0;
                FirstErrTime  <= '0;
                FirstErrChan  <= '0;
                FirstErrType  <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hdlc_rx_protocol_monitor.sv
// Purpose : directed self-checking bench for hdlc_rx_protocol_monitor (1-channel and 4-channel/3-bit-count builds).
// Latency : stimulus changes 1 time unit after each rising edge; outputs are sampled at the same point.
// Backpres: not applicable; the monitor is passive.
module tb_hdlc_rx_protocol_monitor;

    logic Clk = 1'b0;
    logic Rst, En, Clr;

    logic        rx1, fd1, ad1, vf1, as1;
    logic [15:0] cnt1;
    logic        chan1;
    logic [2:0]  type1;
    logic        now1;

    logic [3:0]  rx4, fd4, ad4, vf4, as4;
    logic [2:0]  cnt4;
    logic [3:0]  chan4;
    logic [2:0]  type4;
    logic        now4;

    int nChecks = 0;
    int nPass   = 0;

`ifdef HDLC_MON_FIRST_ERR_CAPTURE_EN
    logic        feVld1, feVld4;
    logic [31:0] feTime1, feTime4;
    logic        feChan1;
    logic [1:0]  feChan4;
    logic [2:0]  feType1, feType4;
`endif

    always #5 Clk = ~Clk;

    hdlc_rx_protocol_monitor u1 (
        .Clk(Clk), .Rst(Rst), .En(En), .Clr(Clr),
        .Rx(rx1), .Rx_FlagDetect(fd1), .Rx_AbortDetect(ad1),
        .Rx_ValidFrame(vf1), .Rx_AbortSignal(as1),
        .ErrCnt(cnt1), .ErrChan(chan1), .ErrType(type1), .ErrNow(now1)
`ifdef HDLC_MON_FIRST_ERR_CAPTURE_EN
        , .FirstErrValid(feVld1), .FirstErrTime(feTime1),
        .FirstErrChan(feChan1), .FirstErrType(feType1)
`endif
    );

    hdlc_rx_protocol_monitor #(.CHANNELS(4), .CNT_W(3)) u4 (
        .Clk(Clk), .Rst(Rst), .En(En), .Clr(Clr),
        .Rx(rx4), .Rx_FlagDetect(fd4), .Rx_AbortDetect(ad4),
        .Rx_ValidFrame(vf4), .Rx_AbortSignal(as4),
        .ErrCnt(cnt4), .ErrChan(chan4), .ErrType(type4), .ErrNow(now4)
`ifdef HDLC_MON_FIRST_ERR_CAPTURE_EN
        , .FirstErrValid(feVld4), .FirstErrTime(feTime4),
        .FirstErrChan(feChan4), .FirstErrType(feType4)
`endif
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear();
        Clr = 1'b1;
        step();
        Clr = 1'b0;
    endtask

    // Drive one byte MSB first on channel 0 of u1; the last bit lands on the final edge.
    task automatic send1(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            rx1 = b[i];
            step();
        end
        rx1 = 1'b0;
    endtask

    task automatic send4(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            rx4 = {4{b[i]}};
            step();
        end
        rx4 = 4'h0;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        step();
        step();
        Rst = 1'b0;
        nChecks++; if (cnt1 !== 16'd0) $display("FAIL reset_cnt: got %0d want 0", cnt1); else nPass++;
        nChecks++; if (chan1 !== 1'b0) $display("FAIL reset_chan: got %0b want 0", chan1); else nPass++;
        nChecks++; if (type1 !== 3'b000) $display("FAIL reset_type: got %03b want 000", type1); else nPass++;
        nChecks++; if (now1 !== 1'b0) $display("FAIL reset_now: got %0b want 0", now1); else nPass++;
        nChecks++; if (cnt4 !== 3'd0) $display("FAIL reset_cnt4: got %0d want 0", cnt4); else nPass++;
    endtask

    task automatic test_flag_ok();
        send1(8'h7E);
        step();
        fd1 = 1'b1;
        step();
        fd1 = 1'b0;
        nChecks++; if (cnt1 !== 16'd0) $display("FAIL flag_ok_cnt: got %0d want 0", cnt1); else nPass++;
        nChecks++; if (type1 !== 3'b000) $display("FAIL flag_ok_type: got %03b want 000", type1); else nPass++;
        step();
        nChecks++; if (now1 !== 1'b0) $display("FAIL flag_ok_now: got %0b want 0", now1); else nPass++;
    endtask

    task automatic test_flag_miss();
        clear();
        send1(8'h7E);
        step();
        nChecks++; if (cnt1 !== 16'd0) $display("FAIL flag_miss_early: got %0d want 0", cnt1); else nPass++;
        step();
        nChecks++; if (cnt1 !== 16'd1) $display("FAIL flag_miss_cnt: got %0d want 1", cnt1); else nPass++;
        nChecks++; if (type1 !== 3'b001) $display("FAIL flag_miss_type: got %03b want 001", type1); else nPass++;
        nChecks++; if (chan1 !== 1'b1) $display("FAIL flag_miss_chan: got %0b want 1", chan1); else nPass++;
        nChecks++; if (now1 !== 1'b1) $display("FAIL flag_miss_now: got %0b want 1", now1); else nPass++;
`ifdef HDLC_MON_FIRST_ERR_CAPTURE_EN
        nChecks++; if (feVld1 !== 1'b1) $display("FAIL first_err_vld: got %0b want 1", feVld1); else nPass++;
        nChecks++; if (feType1 !== 3'b001) $display("FAIL first_err_type: got %03b want 001", feType1); else nPass++;
`endif
        step();
        nChecks++; if (now1 !== 1'b0) $display("FAIL flag_miss_now_drop: got %0b want 0", now1); else nPass++;
        nChecks++; if (cnt1 !== 16'd1) $display("FAIL flag_miss_hold: got %0d want 1", cnt1); else nPass++;
    endtask

    task automatic test_abort();
        clear();
        send1(8'h7F);
        step();
        nChecks++; if (type1 !== 3'b010) $display("FAIL abort_miss_type: got %03b want 010", type1); else nPass++;
        nChecks++; if (cnt1 !== 16'd1) $display("FAIL abort_miss_cnt: got %0d want 1", cnt1); else nPass++;
        send1(8'h7F);
        ad1 = 1'b1;
        step();
        ad1 = 1'b0;
        step();
        nChecks++; if (cnt1 !== 16'd1) $display("FAIL abort_ok_cnt: got %0d want 1", cnt1); else nPass++;
    endtask

    task automatic test_abort_signal();
        clear();
        ad1 = 1'b1; vf1 = 1'b1;
        step();
        ad1 = 1'b0; vf1 = 1'b0;
        step();
        nChecks++; if (type1 !== 3'b100) $display("FAIL abort_sig_type: got %03b want 100", type1); else nPass++;
        nChecks++; if (cnt1 !== 16'd1) $display("FAIL abort_sig_cnt: got %0d want 1", cnt1); else nPass++;
        ad1 = 1'b1; vf1 = 1'b1;
        step();
        ad1 = 1'b0; vf1 = 1'b0; as1 = 1'b1;
        step();
        as1 = 1'b0;
        nChecks++; if (cnt1 !== 16'd1) $display("FAIL abort_sig_ok: got %0d want 1", cnt1); else nPass++;
    endtask

    task automatic test_clr_same_edge();
        clear();
        for (int i = 0; i < 5; i++) begin
            ad1 = 1'b1; vf1 = 1'b1;
            step();
            ad1 = 1'b0; vf1 = 1'b0;
            step();
        end
        nChecks++; if (cnt1 !== 16'd5) $display("FAIL clr_pre_cnt: got %0d want 5", cnt1); else nPass++;
        ad1 = 1'b1; vf1 = 1'b1;
        step();
        ad1 = 1'b0; vf1 = 1'b0; Clr = 1'b1;
        step();
        Clr = 1'b0;
        nChecks++; if (cnt1 !== 16'd1) $display("FAIL clr_same_cnt: got %0d want 1", cnt1); else nPass++;
        nChecks++; if (type1 !== 3'b100) $display("FAIL clr_same_type: got %03b want 100", type1); else nPass++;
        nChecks++; if (now1 !== 1'b1) $display("FAIL clr_same_now: got %0b want 1", now1); else nPass++;
    endtask

    task automatic test_enable();
        clear();
        ad1 = 1'b1; vf1 = 1'b1;
        step();
        En = 1'b0; ad1 = 1'b0; vf1 = 1'b0;
        step();
        nChecks++; if (cnt1 !== 16'd1) $display("FAIL en_pending: got %0d want 1", cnt1); else nPass++;
        send1(8'h7E);
        step(); step(); step();
        send1(8'h7F);
        step(); step();
        En = 1'b1;
        nChecks++; if (cnt1 !== 16'd1) $display("FAIL en_off_nolaunch: got %0d want 1", cnt1); else nPass++;
    endtask

    // Two flags sharing the middle 0: matches at edges 8 and 15, only the first is strobed.
    task automatic test_back_to_back();
        logic [14:0] seq;
        seq = 15'b011111101111110;
        clear();
        for (int e = 1; e <= 17; e++) begin
            rx1 = (e <= 15) ? seq[15-e] : 1'b0;
            fd1 = (e == 10);
            step();
            if (e == 16) begin
                nChecks++; if (cnt1 !== 16'd0) $display("FAIL b2b_first: got %0d want 0", cnt1); else nPass++;
            end
        end
        fd1 = 1'b0;
        rx1 = 1'b0;
        nChecks++; if (cnt1 !== 16'd1) $display("FAIL b2b_second: got %0d want 1", cnt1); else nPass++;
    endtask

    task automatic test_rst_mid();
        logic [5:0] pre;
        pre = 6'b011111;
        clear();
        send1(8'h7E);
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        nChecks++; if (cnt1 !== 16'd0) $display("FAIL rst_cnt: got %0d want 0", cnt1); else nPass++;
        for (int e = 0; e < 8; e++) begin
            step();
            nChecks++; if ((cnt1 !== 16'd0) || (now1 !== 1'b0))
                $display("FAIL rst_flush e%0d: cnt %0d now %0b want 0 0", e, cnt1, now1); else nPass++;
        end
        for (int i = 5; i >= 0; i--) begin
            rx1 = pre[i];
            step();
        end
        Rst = 1'b1; rx1 = 1'b1;
        step();
        Rst = 1'b0;
        for (int e = 0; e < 8; e++) begin
            rx1 = (e == 0);
            step();
            nChecks++; if ((cnt1 !== 16'd0) || (now1 !== 1'b0))
                $display("FAIL rst_hist e%0d: cnt %0d now %0b want 0 0", e, cnt1, now1); else nPass++;
        end
        rx1 = 1'b0;
    endtask

    task automatic test_multi_channel();
        clear();
        send4(8'h7E);
        step(); step();
        nChecks++; if (cnt4 !== 3'd4) $display("FAIL multi_cnt4: got %0d want 4", cnt4); else nPass++;
        nChecks++; if (chan4 !== 4'hF) $display("FAIL multi_chan: got %h want F", chan4); else nPass++;
        nChecks++; if (type4 !== 3'b001) $display("FAIL multi_type: got %03b want 001", type4); else nPass++;
        send4(8'h7E);
        step(); step();
        nChecks++; if (cnt4 !== 3'd7) $display("FAIL multi_sat: got %0d want 7", cnt4); else nPass++;
        clear();
        nChecks++; if (cnt4 !== 3'd0) $display("FAIL multi_clr: got %0d want 0", cnt4); else nPass++;
        send4(8'h7E);
        step();
        fd4 = 4'b1011;
        step();
        fd4 = 4'h0;
        nChecks++; if (cnt4 !== 3'd1) $display("FAIL multi_one_cnt: got %0d want 1", cnt4); else nPass++;
        nChecks++; if (chan4 !== 4'b0100) $display("FAIL multi_one_chan: got %b want 0100", chan4); else nPass++;
        nChecks++; if (cnt1 !== 16'd0) $display("FAIL multi_isolation: got %0d want 0", cnt1); else nPass++;
    endtask

    initial begin
        Rst = 1'b1; En = 1'b1; Clr = 1'b0;
        rx1 = 1'b0; fd1 = 1'b0; ad1 = 1'b0; vf1 = 1'b0; as1 = 1'b0;
        rx4 = 4'h0; fd4 = 4'h0; ad4 = 4'h0; vf4 = 4'h0; as4 = 4'h0;
        test_reset();
        test_flag_ok();
        test_flag_miss();
        test_abort();
        test_abort_signal();
        test_clr_same_edge();
        test_enable();
        test_back_to_back();
        test_rst_mid();
        test_multi_channel();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
